inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 123 ++++++++++++
 tb/tb_inst_fetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: program counter sequencer with IDLE / RUN / HALTED control.
//   Start restarts execution at StartAddr from any state. In RUN the priority
//   is Start, Stall, Halt, taken absolute jump, taken relative branch, then
//   sequential increment (wraps modulo 2**A).
// Parameters:
//   A  - instruction address width
//   OW - signed relative branch offset width
// Ports:
//   Clk, Reset_n        - clock, asynchronous active-low reset
//   Start, StartAddr    - begin execution at StartAddr
//   Stall               - hold ProgCtr and state (RUN only)
//   Halt                - enter HALTED, ProgCtr held
//   BranchAbs, Target   - absolute jump when Taken
//   BranchRel, Offset   - PC-relative branch when Taken
//   ProgCtr             - registered instruction address
//   Busy, Done          - registered RUN / HALTED indications
//   FetchCount          - saturating ProgCtr advance counter (FETCH_COUNT_EN only)
// Build option: define FETCH_COUNT_EN to include FetchCount.
module inst_fetch #(
    parameter int unsigned A  = 10,
    parameter int unsigned OW = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [A-1:0]  StartAddr,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          BranchAbs,
    input  logic          BranchRel,
    input  logic          Taken,
    input  logic [A-1:0]  Target,
    input  logic [OW-1:0] Offset,
    output logic [A-1:0]  ProgCtr,
    output logic          Busy,
    output logic          Done
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]   FetchCount
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [A-1:0] pc_next;
    logic [A-1:0] off_ext;

    // Sign-extend the relative offset to the address width.
    assign off_ext = A'($signed(Offset));

    // State, program counter and status flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            ProgCtr <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_next;
            ProgCtr <= pc_next;
            Busy    <= (state_next == RUN);
            Done    <= (state_next == HALTED);
        end
    end

    // Next-state and next-address selection.
    always_comb begin
        state_next = state;
        pc_next    = ProgCtr;
        case (state)
            IDLE, HALTED: begin
                if (Start) begin
                    pc_next    = StartAddr;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (Start) begin
                    pc_next = StartAddr;
                end else if (Stall) begin
                    pc_next = ProgCtr;
                end else if (Halt) begin
                    state_next = HALTED;
                end else if (BranchAbs && Taken) begin
                    pc_next = Target;
                end else if (BranchRel && Taken) begin
                    pc_next = ProgCtr + off_ext;
                end else begin
                    pc_next = ProgCtr + A'(1);
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = '0;
            end
        endcase
    end

`ifdef FETCH_COUNT_EN
    logic cnt_adv;
    logic cnt_clr;

    // Every RUN edge that moves ProgCtr counts: restart, branch or sequential.
    assign cnt_adv = (state == RUN) && (Start || (!Stall && !Halt));
    assign cnt_clr = (state != RUN) && Start;

    // Saturating fetch counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            FetchCount <= '0;
        end else if (cnt_clr) begin
            FetchCount <= '0;
        end else if (cnt_adv && (FetchCount != 16'hFFFF)) begin
            FetchCount <= FetchCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch (A=10, OW=8).
module tb_inst_fetch;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic [9:0] StartAddr;
    logic       Stall;
    logic       Halt;
    logic       BranchAbs;
    logic       BranchRel;
    logic       Taken;
    logic [9:0] Target;
    logic [7:0] Offset;
    logic [9:0] ProgCtr;
    logic       Busy;
    logic       Done;
`ifdef FETCH_COUNT_EN
    logic [15:0] FetchCount;
`endif

    inst_fetch #(.A(10), .OW(8)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Stall     (Stall),
        .Halt      (Halt),
        .BranchAbs (BranchAbs),
        .BranchRel (BranchRel),
        .Taken     (Taken),
        .Target    (Target),
        .Offset    (Offset),
        .ProgCtr   (ProgCtr),
        .Busy      (Busy),
        .Done      (Done)
`ifdef FETCH_COUNT_EN
        ,
        .FetchCount(FetchCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       start;
        logic [9:0] addr;
        logic       stall;
        logic       halt;
        logic       babs;
        logic       brel;
        logic       taken;
        logic [9:0] target;
        logic [7:0] offset;
        logic [9:0] pc;
        logic       busy;
        logic       done;
    } stim_t;

    typedef struct {
        logic [9:0] pc;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] cnt_q[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic drive(input stim_t s);
        Start     = s.start;
        StartAddr = s.addr;
        Stall     = s.stall;
        Halt      = s.halt;
        BranchAbs = s.babs;
        BranchRel = s.brel;
        Taken     = s.taken;
        Target    = s.target;
        Offset    = s.offset;
    endtask

    task automatic test_reset();
        stim_t tbl[3] = '{
            '{0, 10'd0, 0, 1, 0, 0, 0, 10'd0,  8'h00, 10'd0, 0, 0},
            '{0, 10'd0, 0, 0, 1, 0, 1, 10'd77, 8'h00, 10'd0, 0, 0},
            '{0, 10'd0, 0, 0, 0, 1, 1, 10'd0,  8'h05, 10'd0, 0, 0}
        };
        exp_t e;
        Reset_n = 1'b0;
        drive('{0, 10'd0, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd0, 0, 0});
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (ProgCtr !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pc=%0d busy=%b done=%b expected pc=0 busy=0 done=0",
                     ProgCtr, Busy, Done);
        end
        Reset_n = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back('{tbl[i].pc, tbl[i].busy, tbl[i].done});
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ProgCtr !== e.pc || Busy !== e.busy || Done !== e.done) begin
                failures++;
                $display("FAIL idle_ignore step %0d: pc=%0d busy=%b done=%b expected pc=%0d busy=%b done=%b",
                         i, ProgCtr, Busy, Done, e.pc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_sequential();
        stim_t tbl[4] = '{
            '{1, 10'd5, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd5, 1, 0},
            '{0, 10'd0, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd6, 1, 0},
            '{0, 10'd0, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd7, 1, 0},
            '{0, 10'd0, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd8, 1, 0}
        };
        exp_t e;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back('{tbl[i].pc, tbl[i].busy, tbl[i].done});
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ProgCtr !== e.pc || Busy !== e.busy || Done !== e.done) begin
                failures++;
                $display("FAIL sequential step %0d: pc=%0d busy=%b done=%b expected pc=%0d busy=%b done=%b",
                         i, ProgCtr, Busy, Done, e.pc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_branch_rel();
        stim_t tbl[5] = '{
            '{1, 10'd20, 0, 0, 0, 0, 0, 10'd0,  8'h00, 10'd20, 1, 0},
            '{0, 10'd0,  0, 0, 0, 1, 1, 10'd0,  8'hFC, 10'd16, 1, 0},
            '{1, 10'd20, 0, 0, 0, 0, 0, 10'd0,  8'h00, 10'd20, 1, 0},
            '{0, 10'd0,  0, 0, 0, 1, 0, 10'd0,  8'hFC, 10'd21, 1, 0},
            '{0, 10'd0,  0, 0, 1, 0, 0, 10'd99, 8'h00, 10'd22, 1, 0}
        };
        exp_t e;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back('{tbl[i].pc, tbl[i].busy, tbl[i].done});
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ProgCtr !== e.pc || Busy !== e.busy || Done !== e.done) begin
                failures++;
                $display("FAIL branch_rel step %0d: pc=%0d busy=%b done=%b expected pc=%0d busy=%b done=%b",
                         i, ProgCtr, Busy, Done, e.pc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t tbl[5] = '{
            '{1, 10'h3FF, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'h3FF, 1, 0},
            '{0, 10'd0,   0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd0,   1, 0},
            '{1, 10'd2,   0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd2,   1, 0},
            '{0, 10'd0,   0, 0, 0, 1, 1, 10'd0, 8'hFC, 10'h3FE, 1, 0},
            '{0, 10'd0,   0, 0, 0, 1, 1, 10'd0, 8'h7F, 10'd125, 1, 0}
        };
        exp_t e;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back('{tbl[i].pc, tbl[i].busy, tbl[i].done});
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ProgCtr !== e.pc || Busy !== e.busy || Done !== e.done) begin
                failures++;
                $display("FAIL wrap step %0d: pc=%0d busy=%b done=%b expected pc=%0d busy=%b done=%b",
                         i, ProgCtr, Busy, Done, e.pc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_stall_halt();
        stim_t tbl[5] = '{
            '{1, 10'd30, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd30, 1, 0},
            '{0, 10'd0,  1, 1, 1, 0, 1, 10'd9, 8'h00, 10'd30, 1, 0},
            '{0, 10'd0,  0, 1, 0, 0, 0, 10'd0, 8'h00, 10'd30, 0, 1},
            '{0, 10'd0,  0, 0, 1, 1, 1, 10'd9, 8'h03, 10'd30, 0, 1},
            '{1, 10'd0,  0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd0,  1, 0}
        };
        exp_t e;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back('{tbl[i].pc, tbl[i].busy, tbl[i].done});
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ProgCtr !== e.pc || Busy !== e.busy || Done !== e.done) begin
                failures++;
                $display("FAIL stall_halt step %0d: pc=%0d busy=%b done=%b expected pc=%0d busy=%b done=%b",
                         i, ProgCtr, Busy, Done, e.pc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_abs_reset();
        stim_t tbl[2] = '{
            '{1, 10'd50, 0, 0, 0, 0, 0, 10'd0,   8'h00, 10'd50,  1, 0},
            '{0, 10'd0,  0, 0, 1, 1, 1, 10'd100, 8'h05, 10'd100, 1, 0}
        };
        exp_t e;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back('{tbl[i].pc, tbl[i].busy, tbl[i].done});
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ProgCtr !== e.pc || Busy !== e.busy || Done !== e.done) begin
                failures++;
                $display("FAIL abs_branch step %0d: pc=%0d busy=%b done=%b expected pc=%0d busy=%b done=%b",
                         i, ProgCtr, Busy, Done, e.pc, e.busy, e.done);
            end
        end
        // Pending jump to 200 is set up, then reset hits mid-cycle.
        drive('{0, 10'd0, 0, 0, 1, 0, 1, 10'd200, 8'h00, 10'd0, 0, 0});
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (ProgCtr !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pc=%0d busy=%b done=%b expected pc=0 busy=0 done=0",
                     ProgCtr, Busy, Done);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        exp_q.push_back('{10'd0, 1'b0, 1'b0});
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ProgCtr !== e.pc || Busy !== e.busy || Done !== e.done) begin
            failures++;
            $display("FAIL post_reset_idle: pc=%0d busy=%b done=%b expected pc=%0d busy=%b done=%b",
                     ProgCtr, Busy, Done, e.pc, e.busy, e.done);
        end
    endtask

`ifdef FETCH_COUNT_EN
    task automatic test_fetch_count();
        stim_t tbl[8] = '{
            '{1, 10'd0, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd0, 1, 0},
            '{0, 10'd0, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd1, 1, 0},
            '{0, 10'd0, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd2, 1, 0},
            '{0, 10'd0, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd3, 1, 0},
            '{0, 10'd0, 1, 0, 0, 0, 0, 10'd0, 8'h00, 10'd3, 1, 0},
            '{0, 10'd0, 0, 1, 0, 0, 0, 10'd0, 8'h00, 10'd3, 0, 1},
            '{1, 10'd7, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd7, 1, 0},
            '{1, 10'd9, 0, 0, 0, 0, 0, 10'd0, 8'h00, 10'd9, 1, 0}
        };
        logic [15:0] cnt_tbl[8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd0, 16'd1};
        logic [15:0] c;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            cnt_q.push_back(cnt_tbl[i]);
            @(posedge Clk);
            #1;
            c = cnt_q.pop_front();
            checks++;
            if (FetchCount !== c || ProgCtr !== tbl[i].pc) begin
                failures++;
                $display("FAIL fetch_count step %0d: count=%0d pc=%0d expected count=%0d pc=%0d",
                         i, FetchCount, ProgCtr, c, tbl[i].pc);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch_rel();
        test_wrap();
        test_stall_halt();
        test_abs_reset();
`ifdef FETCH_COUNT_EN
        test_fetch_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
